// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that maps up to NUM_REQ writeback requests onto the two
// write ports of a 2W register file. Per cycle it grants at most two writers,
// never to the same entry, and presents the winners on registered port outputs.
module rf_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           wr1_en_o,
  output logic [ADDR_WIDTH-1:0]          wr1_addr_o,
  output logic [DATA_WIDTH-1:0]          wr1_data_o,
  output logic                           wr2_en_o,
  output logic [ADDR_WIDTH-1:0]          wr2_addr_o,
  output logic [DATA_WIDTH-1:0]          wr2_data_o,
  output logic [15:0]                    conflict_cnt_o
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Unpacked views of the flat request buses
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // State
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr1_en_q, wr1_en_d;
  logic [ADDR_WIDTH-1:0] wr1_addr_q, wr1_addr_d;
  logic [DATA_WIDTH-1:0] wr1_data_q, wr1_data_d;
  logic                  wr2_en_q, wr2_en_d;
  logic [ADDR_WIDTH-1:0] wr2_addr_q, wr2_addr_d;
  logic [DATA_WIDTH-1:0] wr2_data_q, wr2_data_d;

  // Grant selection results
  logic                  found_a, found_b, blocked;
  logic [PTR_W-1:0]      idx_a, idx_b, scan_idx;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0]    ready_c;

  // Scan from rr_ptr: first valid is A, next valid with a different address is B
  always_comb begin
    found_a  = 1'b0;
    found_b  = 1'b0;
    blocked  = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    scan_idx = '0;
    addr_a   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = PTR_W'(rr_ptr_q + PTR_W'(i));
      if (req_valid_i[scan_idx]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = scan_idx;
          addr_a  = addr_arr[scan_idx];
        end else if (addr_arr[scan_idx] == addr_a) begin
          blocked = 1'b1;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = scan_idx;
        end
      end
    end
  end

  // Grants are suppressed while reset is held so nothing transfers then
  always_comb begin
    ready_c = '0;
    if (!rst) begin
      if (found_a) ready_c[idx_a] = 1'b1;
      if (found_b) ready_c[idx_b] = 1'b1;
    end
  end

  assign req_ready_o = ready_c;

  // Next-state: port payloads, pointer advance past last grant, saturating counter
  always_comb begin
    wr1_en_d   = found_a;
    wr1_addr_d = found_a ? addr_arr[idx_a] : '0;
    wr1_data_d = found_a ? data_arr[idx_a] : '0;
    wr2_en_d   = found_b;
    wr2_addr_d = found_b ? addr_arr[idx_b] : '0;
    wr2_data_d = found_b ? data_arr[idx_b] : '0;

    rr_ptr_d = rr_ptr_q;
    if (found_b) begin
      rr_ptr_d = PTR_W'(idx_b + PTR_W'(1));
    end else if (found_a) begin
      rr_ptr_d = PTR_W'(idx_a + PTR_W'(1));
    end

    cnt_d = cnt_q;
    if (blocked && (cnt_q != CNT_MAX)) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      wr1_en_q   <= 1'b0;
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
      wr2_en_q   <= 1'b0;
      wr2_addr_q <= '0;
      wr2_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      wr1_en_q   <= wr1_en_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      wr2_en_q   <= wr2_en_d;
      wr2_addr_q <= wr2_addr_d;
      wr2_data_q <= wr2_data_d;
    end
  end

  assign wr1_en_o       = wr1_en_q;
  assign wr1_addr_o     = wr1_addr_q;
  assign wr1_data_o     = wr1_data_q;
  assign wr2_en_o       = wr2_en_q;
  assign wr2_addr_o     = wr2_addr_q;
  assign wr2_data_o     = wr2_data_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: each step drives requests, checks the
// combinational grant, queues the expected port/counter state and checks it
// after the next clock edge.
module tb_rf_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready_o;
  logic              wr1_en_o;
  logic [AW-1:0]     wr1_addr_o;
  logic [DW-1:0]     wr1_data_o;
  logic              wr2_en_o;
  logic [AW-1:0]     wr2_addr_o;
  logic [DW-1:0]     wr2_data_o;
  logic [15:0]       conflict_cnt_o;

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready_o),
    .wr1_en_o       (wr1_en_o),
    .wr1_addr_o     (wr1_addr_o),
    .wr1_data_o     (wr1_data_o),
    .wr2_en_o       (wr2_en_o),
    .wr2_addr_o     (wr2_addr_o),
    .wr2_data_o     (wr2_data_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          w1_en;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          w2_en;
    logic [AW-1:0] w2_addr;
    logic [DW-1:0] w2_data;
    logic [15:0]   cnt;
  } exp_t;

  exp_t          sb_q [$];
  logic [AW-1:0] a [NR];
  logic [DW-1:0] d [NR];
  int            n_cmp;
  int            n_err;

  // Set requester addresses/data to the distinct default pattern
  task automatic set_distinct();
    for (int k = 0; k < NR; k++) begin
      a[k] = AW'(k + 1);
      d[k] = DW'(32'h1000 + k);
    end
  endtask

  // One clock cycle: drive, check grant, queue expectation, check registered result
  task automatic step(input string tag, input logic r, input logic [NR-1:0] v,
                      input logic [NR-1:0] exp_rdy, input int ia, input int ib,
                      input logic [15:0] exp_cnt);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    for (int k = 0; k < NR; k++) begin
      req_addr[k*AW +: AW] = a[k];
      req_data[k*DW +: DW] = d[k];
    end
    #1;
    n_cmp++;
    assert (req_ready_o === exp_rdy) else begin
      n_err++;
      $error("FAIL %s ready: observed=%b expected=%b", tag, req_ready_o, exp_rdy);
    end
    e = '0;
    if (ia >= 0) begin
      e.w1_en   = 1'b1;
      e.w1_addr = a[ia];
      e.w1_data = d[ia];
    end
    if (ib >= 0) begin
      e.w2_en   = 1'b1;
      e.w2_addr = a[ib];
      e.w2_data = d[ib];
    end
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = {wr1_en_o, wr1_addr_o, wr1_data_o, wr2_en_o, wr2_addr_o, wr2_data_o, conflict_cnt_o};
    n_cmp++;
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s ports: observed wr1=(%b,%0d,%h) wr2=(%b,%0d,%h) cnt=%h expected wr1=(%b,%0d,%h) wr2=(%b,%0d,%h) cnt=%h",
             tag, got.w1_en, got.w1_addr, got.w1_data, got.w2_en, got.w2_addr, got.w2_data, got.cnt,
             e.w1_en, e.w1_addr, e.w1_data, e.w2_en, e.w2_addr, e.w2_data, e.cnt);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    set_distinct();

    // Reset held with all requesters valid: no grants, idle ports
    step("rst0", 1'b1, 4'b1111, 4'b0000, -1, -1, 16'h0000);
    step("rst1", 1'b1, 4'b1111, 4'b0000, -1, -1, 16'h0000);
    step("rst2", 1'b1, 4'b1111, 4'b0000, -1, -1, 16'h0000);

    // Round-robin with all valid and distinct addresses
    step("rr0", 1'b0, 4'b1111, 4'b0011, 0, 1, 16'h0000);
    step("rr1", 1'b0, 4'b1111, 4'b1100, 2, 3, 16'h0000);
    step("rr2", 1'b0, 4'b1111, 4'b0011, 0, 1, 16'h0000);
    step("rr3", 1'b0, 4'b1111, 4'b1100, 2, 3, 16'h0000);

    // Dual grant from pointer 0, distinct addresses
    a[0] = 5'd3; d[0] = 32'h0000_AAAA;
    a[2] = 5'd7; d[2] = 32'h0000_5555;
    step("dual", 1'b0, 4'b0101, 4'b0101, 0, 2, 16'h0000);

    // Pointer 3 wraps to req0; leaves pointer at 1
    a[0] = 5'd10; d[0] = 32'h0000_1234;
    step("wrap", 1'b0, 4'b0001, 4'b0001, 0, -1, 16'h0000);

    // Same-address collision: req3 blocked, then served next
    a[1] = 5'd9; d[1] = 32'h1111_1111;
    a[3] = 5'd9; d[3] = 32'h3333_3333;
    step("coll", 1'b0, 4'b1010, 4'b0010, 1, -1, 16'h0001);
    step("coll_next", 1'b0, 4'b1000, 4'b1000, 3, -1, 16'h0001);

    // Sustained collisions alternate req0/req1 and saturate the counter
    a[0] = 5'd5; d[0] = 32'h0000_0100;
    a[1] = 5'd5; d[1] = 32'h0000_0101;
    for (int k = 0; k < 65540; k++) begin
      step("sat", 1'b0, 4'b0011,
           (k % 2 == 0) ? 4'b0001 : 4'b0010,
           (k % 2 == 0) ? 0 : 1, -1,
           (k + 2 > 65535) ? 16'hFFFF : 16'(k + 2));
    end

    // Back to distinct traffic; pointer sits at 2 after the collision run
    set_distinct();
    step("post_sat0", 1'b0, 4'b1111, 4'b1100, 2, 3, 16'hFFFF);
    step("post_sat1", 1'b0, 4'b1111, 4'b0011, 0, 1, 16'hFFFF);

    // Reset mid-stream with pointer at 2: nothing granted, all state cleared
    step("mid_rst", 1'b1, 4'b1111, 4'b0000, -1, -1, 16'h0000);
    step("after_rst", 1'b0, 4'b1111, 4'b0011, 0, 1, 16'h0000);
    step("idle", 1'b0, 4'b0000, 4'b0000, -1, -1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
